// File: rtl/button_pkg.sv
// Shared definitions for the multi-channel button debouncer: edge-select
// encodings and the default debounce interval (10 ms at 100 MHz).
package button_pkg;

  typedef enum logic [1:0] {
    MODE_FALL = 2'b00,
    MODE_RISE = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Edge-select for a single channel; MODE_NONE masks both pulse kinds.
  function automatic logic sel_pulse(input mode_e m, input logic rise, input logic fall);
    logic res;
    res = 1'b0;
    case (m)
      MODE_FALL: res = fall;
      MODE_RISE: res = rise;
      MODE_BOTH: res = rise | fall;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level
// and single-cycle rise/fall pulses registered on the same edge as the level.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_button,
  output logic o_stable,
  output logic o_pulse_rise,
  output logic o_pulse_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [CNT_W-1:0] r_cnt_p2;
  logic             r_stable_p2;
  logic             r_rise_p2;
  logic             r_fall_p2;

  logic w_diff;
  logic w_done;

  // A mismatch that has already persisted CNT_LAST cycles is accepted now.
  assign w_diff = r_sync_p1 ^ r_stable_p2;
  assign w_done = w_diff && (r_cnt_p2 == CNT_LAST);

  // p0/p1: metastability chain on the raw asynchronous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_button;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // p2: stability counter, debounced level and edge pulses share one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_p2    <= '0;
      r_stable_p2 <= 1'b0;
      r_rise_p2   <= 1'b0;
      r_fall_p2   <= 1'b0;
    end else begin
      r_rise_p2 <= w_done & r_sync_p1;
      r_fall_p2 <= w_done & ~r_sync_p1;
      if (!w_diff) begin
        r_cnt_p2 <= '0;
      end else if (w_done) begin
        r_stable_p2 <= r_sync_p1;
        r_cnt_p2    <= '0;
      end else begin
        r_cnt_p2 <= r_cnt_p2 + CNT_W'(1);
      end
    end
  end

  assign o_stable     = r_stable_p2;
  assign o_pulse_rise = r_rise_p2;
  assign o_pulse_fall = r_fall_p2;

endmodule

// File: rtl/button_debounce_edge.sv
// Multi-channel button debouncer: N_CH independent debounce channels plus a
// combinational, mode-selected view of their registered edge pulses.
module button_debounce_edge
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] pulse_fall,
  output logic [N_CH-1:0] pulse_rise,
  output logic [N_CH-1:0] pulse_sel
);

  logic [N_CH-1:0] w_sel;
  mode_e           w_mode;

  assign w_mode = mode_e'(mode);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_button    (button[g]),
      .o_stable    (stable[g]),
      .o_pulse_rise(pulse_rise[g]),
      .o_pulse_fall(pulse_fall[g])
    );
  end

  // Mode is applied after the pulse registers so a mode change never creates a pulse.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sel[i] = sel_pulse(w_mode, pulse_rise[i], pulse_fall[i]);
    end
  end

  assign pulse_sel = w_sel;

endmodule

// File: tb/tb_button_debounce_edge.sv
// Directed bench for button_debounce_edge with DEBOUNCE_CYCLES=4, N_CH=4:
// a clean level change shows up as a pulse 6 posedges after it is driven.
module tb_button_debounce_edge;

  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] button;
  logic [1:0]   mode;
  logic [N-1:0] stable;
  logic [N-1:0] pulse_fall;
  logic [N-1:0] pulse_rise;
  logic [N-1:0] pulse_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rise[N];
  int n_fall[N];
  int n_sel[N];

  button_debounce_edge #(
    .N_CH(N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .mode      (mode),
    .stable    (stable),
    .pulse_fall(pulse_fall),
    .pulse_rise(pulse_rise),
    .pulse_sel (pulse_sel)
  );

  always #5 clk = ~clk;

  initial begin
    for (int c = 0; c < N; c++) begin
      n_rise[c] = 0;
      n_fall[c] = 0;
      n_sel[c]  = 0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      n_rise[c] += int'(pulse_rise[c]);
      n_fall[c] += int'(pulse_fall[c]);
      n_sel[c]  += int'(pulse_sel[c]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 4'hF; mode = 2'b00;
    repeat (3) tick();
    n_checks++;
    if (stable !== 4'h0) begin n_fail++; $display("FAIL reset_stable: got %h expected %h", stable, 4'h0); end
    n_checks++;
    if ({pulse_rise, pulse_fall} !== 8'h00) begin n_fail++; $display("FAIL reset_pulses: got %h expected %h", {pulse_rise, pulse_fall}, 8'h00); end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (pulse_rise !== 4'h0) begin n_fail++; $display("FAIL reset_early_rise cyc%0d: got %h expected %h", i, pulse_rise, 4'h0); end
    end
    tick();
    n_checks++;
    if (pulse_rise !== 4'hF) begin n_fail++; $display("FAIL reset_rise: got %h expected %h", pulse_rise, 4'hF); end
    n_checks++;
    if (stable !== 4'hF) begin n_fail++; $display("FAIL reset_stable_hi: got %h expected %h", stable, 4'hF); end
    tick();
    n_checks++;
    if (pulse_rise !== 4'h0 || stable !== 4'hF) begin n_fail++; $display("FAIL reset_after: got rise %h stable %h expected rise 0 stable f", pulse_rise, stable); end
    button = 4'h0;
    repeat (8) tick();
    n_checks++;
    if (stable !== 4'h0) begin n_fail++; $display("FAIL reset_release: got %h expected %h", stable, 4'h0); end
  endtask

  task automatic test_press_release();
    int br, bf, bs;
    br = n_rise[0]; bf = n_fall[0]; bs = n_sel[0];
    mode = 2'b00;
    button = 4'b0001;
    repeat (5) tick();
    n_checks++;
    if (pulse_rise !== 4'h0 || stable !== 4'h0) begin n_fail++; $display("FAIL press_early: got rise %h stable %h expected 0 0", pulse_rise, stable); end
    tick();
    n_checks++;
    if (pulse_rise !== 4'b0001) begin n_fail++; $display("FAIL press_rise: got %h expected %h", pulse_rise, 4'b0001); end
    n_checks++;
    if (pulse_sel !== 4'b0000) begin n_fail++; $display("FAIL press_sel_fallmode: got %h expected %h", pulse_sel, 4'b0000); end
    repeat (4) tick();
    button = 4'b0000;
    repeat (5) tick();
    n_checks++;
    if (pulse_fall !== 4'h0 || stable !== 4'b0001) begin n_fail++; $display("FAIL release_early: got fall %h stable %h expected 0 1", pulse_fall, stable); end
    tick();
    n_checks++;
    if (pulse_fall !== 4'b0001 || pulse_sel !== 4'b0001) begin n_fail++; $display("FAIL release_fall: got fall %h sel %h expected 1 1", pulse_fall, pulse_sel); end
    n_checks++;
    if (stable !== 4'b0000) begin n_fail++; $display("FAIL release_stable: got %h expected %h", stable, 4'b0000); end
    repeat (3) tick();
    n_checks++;
    if (n_rise[0] - br !== 1 || n_fall[0] - bf !== 1 || n_sel[0] - bs !== 1) begin
      n_fail++; $display("FAIL press_counts: got rise %0d fall %0d sel %0d expected 1 1 1", n_rise[0] - br, n_fall[0] - bf, n_sel[0] - bs);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] seq;
    int br;
    seq = 5'b10101;
    br = n_rise[1];
    for (int k = 0; k < 4; k++) begin
      button = {2'b00, seq[k], 1'b0};
      repeat (2) begin
        tick();
        n_checks++;
        if (stable[1] !== 1'b0 || pulse_rise[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_quiet k%0d: got stable %b rise %b expected 0 0", k, stable[1], pulse_rise[1]); end
      end
    end
    button = 4'b0010;
    repeat (5) tick();
    n_checks++;
    if (stable[1] !== 1'b0 || pulse_rise[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_early: got stable %b rise %b expected 0 0", stable[1], pulse_rise[1]); end
    tick();
    n_checks++;
    if (pulse_rise !== 4'b0010 || stable !== 4'b0010) begin n_fail++; $display("FAIL bounce_rise: got rise %h stable %h expected 2 2", pulse_rise, stable); end
    tick();
    n_checks++;
    if (n_rise[1] - br !== 1) begin n_fail++; $display("FAIL bounce_count: got %0d expected 1", n_rise[1] - br); end
    button = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_mode_sweep();
    int br, bf, bs;
    mode = 2'b10;
    br = n_rise[0]; bf = n_fall[0]; bs = n_sel[0];
    button = 4'b0001; repeat (8) tick();
    button = 4'b0000; repeat (8) tick();
    n_checks++;
    if (n_sel[0] - bs !== 2) begin n_fail++; $display("FAIL mode_both_sel: got %0d expected 2", n_sel[0] - bs); end
    mode = 2'b11;
    br = n_rise[0]; bf = n_fall[0]; bs = n_sel[0];
    button = 4'b0001; repeat (8) tick();
    button = 4'b0000; repeat (8) tick();
    n_checks++;
    if (n_sel[0] - bs !== 0 || n_rise[0] - br !== 1 || n_fall[0] - bf !== 1) begin
      n_fail++; $display("FAIL mode_none: got sel %0d rise %0d fall %0d expected 0 1 1", n_sel[0] - bs, n_rise[0] - br, n_fall[0] - bf);
    end
    mode = 2'b00;
    button = 4'b0001;
    repeat (6) tick();
    n_checks++;
    if (pulse_rise !== 4'b0001 || pulse_sel !== 4'b0000) begin n_fail++; $display("FAIL mode_switch_pre: got rise %h sel %h expected 1 0", pulse_rise, pulse_sel); end
    mode = 2'b01; #1;
    n_checks++;
    if (pulse_sel !== 4'b0001) begin n_fail++; $display("FAIL mode_switch_rise: got %h expected %h", pulse_sel, 4'b0001); end
    mode = 2'b11; #1;
    n_checks++;
    if (pulse_sel !== 4'b0000) begin n_fail++; $display("FAIL mode_switch_none: got %h expected %h", pulse_sel, 4'b0000); end
    mode = 2'b10; #1;
    n_checks++;
    if (pulse_sel !== 4'b0001) begin n_fail++; $display("FAIL mode_switch_both: got %h expected %h", pulse_sel, 4'b0001); end
    mode = 2'b00;
    button = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_multi_channel();
    int b2;
    button = 4'b0101;
    repeat (5) tick();
    n_checks++;
    if (pulse_rise !== 4'h0) begin n_fail++; $display("FAIL multi_early: got %h expected %h", pulse_rise, 4'h0); end
    tick();
    n_checks++;
    if (pulse_rise !== 4'b0101 || pulse_fall !== 4'b0000) begin n_fail++; $display("FAIL multi_rise: got rise %h fall %h expected 5 0", pulse_rise, pulse_fall); end
    repeat (2) tick();
    b2 = n_fall[2] + n_rise[2];
    button = 4'b0100;
    repeat (6) tick();
    n_checks++;
    if (pulse_fall !== 4'b0001 || pulse_rise !== 4'b0000) begin n_fail++; $display("FAIL multi_fall: got fall %h rise %h expected 1 0", pulse_fall, pulse_rise); end
    n_checks++;
    if (stable !== 4'b0100) begin n_fail++; $display("FAIL multi_stable: got %h expected %h", stable, 4'b0100); end
    repeat (2) tick();
    n_checks++;
    if (n_fall[2] + n_rise[2] !== b2) begin n_fail++; $display("FAIL multi_ch2_quiet: got %0d expected %0d", n_fall[2] + n_rise[2], b2); end
    button = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_count();
    int br;
    br = n_rise[3];
    button = 4'b1000;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (stable !== 4'h0 || pulse_rise !== 4'h0) begin n_fail++; $display("FAIL midrst_during: got stable %h rise %h expected 0 0", stable, pulse_rise); end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (pulse_rise !== 4'h0) begin n_fail++; $display("FAIL midrst_early cyc%0d: got %h expected %h", i, pulse_rise, 4'h0); end
    end
    tick();
    n_checks++;
    if (pulse_rise !== 4'b1000 || stable !== 4'b1000) begin n_fail++; $display("FAIL midrst_rise: got rise %h stable %h expected 8 8", pulse_rise, stable); end
    tick();
    n_checks++;
    if (n_rise[3] - br !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", n_rise[3] - br); end
  endtask

  initial begin
    rst = 1'b1; button = '0; mode = 2'b00;
    test_reset();
    test_press_release();
    test_bounce();
    test_mode_sweep();
    test_multi_channel();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
